// File: rtl/addr_seq_ctrl_pkg.sv
// Shared definitions for the address-sequence controller: FSM encoding and
// default run geometry.
package addr_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_NUM_OPS  = 16;
  localparam int DEF_PIPE_LAT = 2;
  localparam int DEF_CNT_W    = 5;

endpackage

// File: rtl/addr_seq_ctrl_en_delay_line.sv
// Enable shift register that realigns read strobes with the datapath latency.
// A stall freezes the contents and masks the output so no pulse is lost.
module en_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  input  logic en_i,
  output logic en_o
);

  logic [DEPTH-1:0] dl_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dl_q <= '0;
        end else if (!hold_i) begin
          dl_q <= en_i;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dl_q <= '0;
        end else if (!hold_i) begin
          dl_q <= {dl_q[DEPTH-2:0], en_i};
        end
      end
    end
  endgenerate

  assign en_o = dl_q[DEPTH-1] & ~hold_i;

endmodule

// File: rtl/addr_seq_ctrl.sv
// Turns one go request into NUM_OPS read strobes followed, PIPE_LAT unstalled
// cycles later each, by matching write strobes; pulses done after the last write.
module addr_seq_ctrl
  import addr_seq_ctrl_pkg::*;
#(
  parameter int NUM_OPS  = DEF_NUM_OPS,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             hold,
  output logic             ReadEn,
  output logic             Start,
  output logic             WriteEn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] iss_cnt_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic             start_w;

  en_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_dl (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (hold),
    .en_i   (ReadEn),
    .en_o   (start_w)
  );

  assign ReadEn  = (state_q == ST_ISSUE) & ~hold;
  assign Start   = start_w;
  assign WriteEn = start_w;
  assign busy    = (state_q == ST_ISSUE) | (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);
  assign op_cnt  = iss_cnt_q;

  // Writes can overlap reads in ISSUE, so wr_cnt advances in both run states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      iss_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q   <= ST_ISSUE;
            iss_cnt_q <= '0;
            wr_cnt_q  <= '0;
          end
        end
        ST_ISSUE: begin
          if (ReadEn) begin
            iss_cnt_q <= iss_cnt_q + 1'b1;
            if (iss_cnt_q == LAST_OP) state_q <= ST_DRAIN;
          end
          if (start_w) wr_cnt_q <= wr_cnt_q + 1'b1;
        end
        ST_DRAIN: begin
          if (start_w) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_OP) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Randomised and directed bench for addr_seq_ctrl: two instances (4 ops/lat 2
// and 1 op/lat 1) share stimulus; a token-based model predicts every cycle.
module tb_addr_seq_ctrl;

  typedef struct packed {
    logic       readen;
    logic       start;
    logic       writeen;
    logic       busy;
    logic       done;
    logic [4:0] op;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       hold = 1'b0;
  logic       re0, st0, we0, busy0, done0;
  logic [4:0] op0;
  logic       re1, st1, we1, busy1, done1;
  logic [4:0] op1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Model state per instance: a run has reads/writes left, and each issued
  // read becomes a token counting down the unstalled cycles until its write.
  int m_run[2], m_done[2], m_rleft[2], m_wleft[2], m_op[2], m_ntok[2];
  int m_tok[2][8];

  always #5 clk = ~clk;

  addr_seq_ctrl #(.NUM_OPS(4), .PIPE_LAT(2), .CNT_W(5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .go(go), .hold(hold),
    .ReadEn(re0), .Start(st0), .WriteEn(we0), .busy(busy0), .done(done0), .op_cnt(op0)
  );

  addr_seq_ctrl #(.NUM_OPS(1), .PIPE_LAT(1), .CNT_W(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .go(go), .hold(hold),
    .ReadEn(re1), .Start(st1), .WriteEn(we1), .busy(busy1), .done(done1), .op_cnt(op1)
  );

  task automatic model_step(input int d, input int nops, input int plat,
                            input logic g, input logic h, input logic r,
                            output exp_t e);
    logic rd, wr;
    rd = (m_run[d] != 0) && (m_rleft[d] > 0) && !h;
    wr = !h && (m_ntok[d] > 0) && (m_tok[d][0] == 1);
    e.readen  = rd;
    e.start   = wr;
    e.writeen = wr;
    e.busy    = (m_run[d] != 0);
    e.done    = (m_done[d] != 0);
    e.op      = 5'(m_op[d]);
    if (!r) begin
      m_run[d] = 0; m_done[d] = 0; m_rleft[d] = 0; m_wleft[d] = 0;
      m_op[d] = 0; m_ntok[d] = 0;
    end else if (m_done[d] != 0) begin
      m_done[d] = 0;
    end else if (m_run[d] == 0) begin
      if (g) begin
        m_run[d] = 1; m_rleft[d] = nops; m_wleft[d] = nops; m_op[d] = 0; m_ntok[d] = 0;
      end
    end else if (!h) begin
      if (wr) begin
        for (int k = 0; k < 7; k++) m_tok[d][k] = m_tok[d][k+1];
        m_ntok[d]--;
        m_wleft[d]--;
      end
      for (int k = 0; k < m_ntok[d]; k++) m_tok[d][k]--;
      if (rd) begin
        m_tok[d][m_ntok[d]] = plat;
        m_ntok[d]++;
        m_rleft[d]--;
        m_op[d]++;
      end
      if (m_wleft[d] == 0) begin
        m_run[d] = 0;
        m_done[d] = 1;
      end
    end
  endtask

  task automatic cyc(input logic g, input logic h, input logic r);
    exp_t e0, e1;
    @(posedge clk);
    #1;
    go = g; hold = h; rst_n = r;
    model_step(0, 4, 2, g, h, r, e0);
    model_step(1, 1, 1, g, h, r, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle the outputs are the DUT's response; compare mid-cycle.
  initial begin
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = {re0, st0, we0, busy0, done0, op0};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL dut0_outputs t=%0t got re/st/we/busy/done/op=%b%b%b%b%b/%0d want %b%b%b%b%b/%0d",
                   $time, a.readen, a.start, a.writeen, a.busy, a.done, a.op,
                   e.readen, e.start, e.writeen, e.busy, e.done, e.op);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {re1, st1, we1, busy1, done1, op1};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL dut1_outputs t=%0t got re/st/we/busy/done/op=%b%b%b%b%b/%0d want %b%b%b%b%b/%0d",
                   $time, a.readen, a.start, a.writeen, a.busy, a.done, a.op,
                   e.readen, e.start, e.writeen, e.busy, e.done, e.op);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_done[d] = 0; m_rleft[d] = 0; m_wleft[d] = 0;
      m_op[d] = 0; m_ntok[d] = 0;
      for (int k = 0; k < 8; k++) m_tok[d][k] = 0;
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    idle(2);

    // Single go pulse, no stall.
    cyc(1'b1, 1'b0, 1'b1);
    idle(10);
    $display("run1 plain go done, compared=%0d", n_cmp);

    // Stall in run cycles 2-3.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    idle(12);
    $display("run2 hold done, compared=%0d", n_cmp);

    // Stray go pulses in ISSUE, DRAIN and DONE.
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) cyc((i == 2) || (i == 5) || (i == 7), 1'b0, 1'b1);
    idle(4);
    $display("run3 stray go done, compared=%0d", n_cmp);

    // Reset mid-run, then a clean run.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    idle(10);
    cyc(1'b1, 1'b0, 1'b1);
    idle(12);
    $display("run4 mid-run reset done, compared=%0d", n_cmp);

    // go held high: back-to-back runs.
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b1);
    idle(12);
    $display("run5 go held done, compared=%0d", n_cmp);

    // Random go/hold with rare resets.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 99) != 0);
    idle(12);
    $display("random phase done, compared=%0d", n_cmp);

    @(posedge clk);
    @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
